// File: rtl/conv_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mem_responder_pkg
//  Description : Shared widths, bank-select codes and FSM encoding for the
//                convolution memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_mem_responder_pkg;

    // Data width and address widths of the image / layer memories
    localparam int DW   = 20;
    localparam int IAW  = 12;
    localparam int L1AW = 10;

    // Engine bank-select codes
    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    // Responder state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmr_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cmr_ram
//  Description : Simple RAM, one synchronous write port and two asynchronous
//                read ports. Reads return pre-edge contents, so a same-cycle
//                read of the written address sees the old data.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmr_ram #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is not reset; contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mem_responder
//  Description : Memory-side responder for a convolution engine. Holds the
//                input image (IMG) and two layer buffers (L0, L1), sequences
//                IDLE -> READY -> RUN -> DONE handshaking with the engine,
//                counts RUN cycles with a timeout, and flags misuse in a
//                sticky error bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mem_responder #(
    parameter int          DW      = conv_mem_responder_pkg::DW,
    parameter int          IAW     = conv_mem_responder_pkg::IAW,
    parameter int          L1AW    = conv_mem_responder_pkg::L1AW,
    parameter logic [23:0] TIMEOUT = 24'd200000
) (
    input  logic                  clk,
    input  logic                  reset,
    // host side
    input  logic                  host_we,
    input  logic [IAW-1:0]        host_addr,
    input  logic [DW-1:0]         host_wdata,
    input  logic                  host_go,
    input  logic                  host_clr,
    input  logic                  host_rsel,
    input  logic [IAW-1:0]        host_raddr,
    output logic [DW-1:0]         host_rdata,
    // engine side
    output logic                  ready,
    input  logic                  busy,
    input  logic [IAW-1:0]        iaddr,
    output logic signed [DW-1:0]  idata,
    input  logic                  cwr,
    input  logic [IAW-1:0]        caddr_wr,
    input  logic [DW-1:0]         cdata_wr,
    input  logic                  crd,
    input  logic [IAW-1:0]        caddr_rd,
    output logic [DW-1:0]         cdata_rd,
    input  logic [2:0]            csel,
    // status
    output logic                  done,
    output logic                  err,
    output logic [23:0]           run_cycles
);

    import conv_mem_responder_pkg::*;

    state_t        r_state;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic          r_busy;
    logic [23:0]   r_run_cycles;

    logic          w_in_idle;
    logic          w_in_run;
    logic          w_sel_l0;
    logic          w_sel_l1;
    logic          w_l1_addr_ok;
    logic          w_img_we;
    logic          w_l0_we;
    logic          w_l1_we;
    logic          w_err_set;
    logic [23:0]   w_run_next;

    logic [DW-1:0] w_img_rdata;
    logic [DW-1:0] w_img_rdata_unused;
    logic [DW-1:0] w_l0_rd_eng;
    logic [DW-1:0] w_l0_rd_host;
    logic [DW-1:0] w_l1_rd_eng;
    logic [DW-1:0] w_l1_rd_host;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_run     = (r_state == ST_RUN);
    assign w_sel_l0     = (csel == CSEL_L0);
    assign w_sel_l1     = (csel == CSEL_L1);
    // L1 is only 1K deep; any upper address bit set is an out-of-range write
    assign w_l1_addr_ok = (caddr_wr[IAW-1:L1AW] == '0);

    assign w_img_we = w_in_idle & host_we;
    assign w_l0_we  = w_in_run & cwr & w_sel_l0;
    assign w_l1_we  = w_in_run & cwr & w_sel_l1 & w_l1_addr_ok;

    // Strobes outside RUN, or a RUN write that no bank accepted, are errors
    assign w_err_set = (~w_in_run & (cwr | crd)) |
                       (w_in_run & cwr & ~w_l0_we & ~w_l1_we);

    // RUN-cycle counter saturates rather than wrapping
    assign w_run_next = (r_run_cycles == 24'hFFFFFF) ? r_run_cycles
                                                     : r_run_cycles + 24'd1;

    cmr_ram #(.WIDTH(DW), .DEPTH(1 << IAW), .AW(IAW)) u_img (
        .clk       (clk),
        .i_we      (w_img_we),
        .i_waddr   (host_addr),
        .i_wdata   (host_wdata),
        .i_raddr_a (iaddr),
        .o_rdata_a (w_img_rdata),
        .i_raddr_b (host_addr),
        .o_rdata_b (w_img_rdata_unused)
    );

    cmr_ram #(.WIDTH(DW), .DEPTH(1 << IAW), .AW(IAW)) u_l0 (
        .clk       (clk),
        .i_we      (w_l0_we),
        .i_waddr   (caddr_wr),
        .i_wdata   (cdata_wr),
        .i_raddr_a (caddr_rd),
        .o_rdata_a (w_l0_rd_eng),
        .i_raddr_b (host_raddr),
        .o_rdata_b (w_l0_rd_host)
    );

    cmr_ram #(.WIDTH(DW), .DEPTH(1 << L1AW), .AW(L1AW)) u_l1 (
        .clk       (clk),
        .i_we      (w_l1_we),
        .i_waddr   (caddr_wr[L1AW-1:0]),
        .i_wdata   (cdata_wr),
        .i_raddr_a (caddr_rd[L1AW-1:0]),
        .o_rdata_a (w_l1_rd_eng),
        .i_raddr_b (host_raddr[L1AW-1:0]),
        .o_rdata_b (w_l1_rd_host)
    );

    assign idata      = w_img_rdata;
    assign host_rdata = host_rsel ? w_l1_rd_host : w_l0_rd_host;

    // Engine layer read mux; idle value is zero
    always_comb begin
        cdata_rd = '0;
        if (crd && w_sel_l0) begin
            cdata_rd = w_l0_rd_eng;
        end else if (crd && w_sel_l1) begin
            cdata_rd = w_l1_rd_eng;
        end
    end

    // Sequencer with registered ready/done, sticky error and RUN counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_run_cycles <= 24'd0;
        end else begin
            r_busy <= busy;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (host_go) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (busy) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_run_cycles <= w_run_next;
                    if (w_run_next >= TIMEOUT) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (r_busy && !busy) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (host_clr) begin
                        r_state      <= ST_IDLE;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_run_cycles <= 24'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_mem_responder
//  Description : Directed bench for conv_mem_responder. A behavioural model
//                tracks phase, counters and memory contents and is compared
//                against the DUT every cycle; literal expectations pin the
//                key scenarios. A second instance with a short timeout
//                covers the RUN timeout path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mem_responder;

    localparam logic [23:0] TIMEOUT_MAIN = 24'd200000;
    localparam logic [23:0] TIMEOUT_SHORT = 24'd50;

    logic               clk = 1'b0;
    logic               reset;
    logic               host_we, host_go, host_clr, host_rsel;
    logic [11:0]        host_addr, host_raddr;
    logic [19:0]        host_wdata;
    logic               busy, busy_to;
    logic [11:0]        iaddr, caddr_wr, caddr_rd;
    logic               cwr, crd;
    logic [19:0]        cdata_wr;
    logic [2:0]         csel;

    logic [19:0]        host_rdata, host_rdata_to;
    logic               ready, ready_to;
    logic signed [19:0] idata, idata_to;
    logic [19:0]        cdata_rd, cdata_rd_to;
    logic               done, done_to, err, err_to;
    logic [23:0]        run_cycles, run_cycles_to;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    conv_mem_responder #(.TIMEOUT(TIMEOUT_MAIN)) dut (
        .clk(clk), .reset(reset),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_go(host_go), .host_clr(host_clr), .host_rsel(host_rsel),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .done(done), .err(err), .run_cycles(run_cycles)
    );

    conv_mem_responder #(.TIMEOUT(TIMEOUT_SHORT)) dut_to (
        .clk(clk), .reset(reset),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_go(host_go), .host_clr(host_clr), .host_rsel(host_rsel),
        .host_raddr(host_raddr), .host_rdata(host_rdata_to),
        .ready(ready_to), .busy(busy_to), .iaddr(iaddr), .idata(idata_to),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd_to), .csel(csel),
        .done(done_to), .err(err_to), .run_cycles(run_cycles_to)
    );

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main instance ----------------
    // phase: 0 idle, 1 waiting for engine, 2 engine running, 3 finished
    int          m_phase = 0;
    logic        m_err = 1'b0;
    logic        m_busy_prev = 1'b0;
    logic [23:0] m_cycles = 24'd0;
    logic [19:0] m_img [4096];
    bit          m_img_v [4096];
    logic [19:0] m_l0 [4096];
    bit          m_l0_v [4096];
    logic [19:0] m_l1 [1024];
    bit          m_l1_v [1024];

    task automatic model_step();
        bit running;
        if (!reset) begin
            m_phase = 0; m_err = 1'b0; m_cycles = 24'd0; m_busy_prev = 1'b0;
            return;
        end
        running = (m_phase == 2);
        if (m_phase == 0 && host_we) begin
            m_img[host_addr] = host_wdata; m_img_v[host_addr] = 1'b1;
        end
        if (!running && (cwr || crd)) m_err = 1'b1;
        if (running && cwr) begin
            if (csel == 3'b001) begin
                m_l0[caddr_wr] = cdata_wr; m_l0_v[caddr_wr] = 1'b1;
            end else if (csel == 3'b011 && caddr_wr < 12'd1024) begin
                m_l1[caddr_wr[9:0]] = cdata_wr; m_l1_v[caddr_wr[9:0]] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        case (m_phase)
            0: if (host_go) m_phase = 1;
            1: if (busy) m_phase = 2;
            2: begin
                if (m_cycles != 24'hFFFFFF) m_cycles = m_cycles + 24'd1;
                if (m_cycles >= TIMEOUT_MAIN) begin
                    m_err = 1'b1; m_phase = 3;
                end else if (m_busy_prev && !busy) begin
                    m_phase = 3;
                end
            end
            default: if (host_clr) begin
                m_phase = 0; m_cycles = 24'd0; m_err = 1'b0;
            end
        endcase
        m_busy_prev = busy;
    endtask

    task automatic model_check();
        logic [19:0] exp_rd;
        bit          rd_known;
        if (!reset) begin
            chk("model.ready", {23'd0, ready}, 24'd0);
            chk("model.done", {23'd0, done}, 24'd0);
            chk("model.err", {23'd0, err}, 24'd0);
            chk("model.run_cycles", run_cycles, 24'd0);
            return;
        end
        chk("model.ready", {23'd0, ready}, {23'd0, m_phase == 1});
        chk("model.done", {23'd0, done}, {23'd0, m_phase == 3});
        chk("model.err", {23'd0, err}, {23'd0, m_err});
        chk("model.run_cycles", run_cycles, m_cycles);
        if (m_img_v[iaddr]) chk("model.idata", {4'd0, $unsigned(idata)}, {4'd0, m_img[iaddr]});
        if (host_rsel) begin
            if (m_l1_v[host_raddr[9:0]])
                chk("model.host_rdata.l1", {4'd0, host_rdata}, {4'd0, m_l1[host_raddr[9:0]]});
        end else if (m_l0_v[host_raddr]) begin
            chk("model.host_rdata.l0", {4'd0, host_rdata}, {4'd0, m_l0[host_raddr]});
        end
        if (m_phase == 2) begin
            rd_known = 1'b1;
            exp_rd   = 20'd0;
            if (crd && csel == 3'b001) begin
                rd_known = m_l0_v[caddr_rd]; exp_rd = m_l0[caddr_rd];
            end else if (crd && csel == 3'b011) begin
                rd_known = m_l1_v[caddr_rd[9:0]]; exp_rd = m_l1[caddr_rd[9:0]];
            end
            if (rd_known) chk("model.cdata_rd", {4'd0, cdata_rd}, {4'd0, exp_rd});
        end
    endtask

    // Single compare process: advance the model on the edge, check mid-cycle
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            model_check();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        host_we = 1'b0; host_go = 1'b0; host_clr = 1'b0; host_rsel = 1'b0;
        host_addr = '0; host_raddr = '0; host_wdata = '0;
        busy = 1'b0; busy_to = 1'b0; iaddr = '0; caddr_wr = '0; caddr_rd = '0;
        cwr = 1'b0; crd = 1'b0; cdata_wr = '0; csel = 3'b000;

        repeat (2) tick();
        at_neg();
        chk("rst.ready", {23'd0, ready}, 24'd0);
        chk("rst.done", {23'd0, done}, 24'd0);
        chk("rst.err", {23'd0, err}, 24'd0);
        chk("rst.run_cycles", run_cycles, 24'd0);
        tick(); reset = 1'b1;

        // image loads, including both address extremes
        tick(); host_we = 1'b1; host_addr = 12'd5;    host_wdata = 20'h12345;
        tick(); host_addr = 12'd0;   host_wdata = 20'h0000F;
        tick(); host_addr = 12'hFFF; host_wdata = 20'hFFFFF;
        tick(); host_we = 1'b0; host_clr = 1'b1; iaddr = 12'd5;
        at_neg();
        chk("idata.img5", {4'd0, $unsigned(idata)}, 24'h012345);
        chk("idle.clr_ignored", {23'd0, ready}, 24'd0);
        tick(); host_clr = 1'b0; iaddr = 12'hFFF;
        at_neg();
        chk("idata.imgFFF", {4'd0, $unsigned(idata)}, 24'h0FFFFF);

        // write and go in the same cycle
        tick(); host_we = 1'b1; host_addr = 12'd7; host_wdata = 20'h54321; host_go = 1'b1;
        tick(); host_we = 1'b0; host_go = 1'b0; iaddr = 12'd7;
        at_neg();
        chk("ready.after_go", {23'd0, ready}, 24'd1);
        chk("idata.img7", {4'd0, $unsigned(idata)}, 24'h054321);
        tick(); host_go = 1'b1;
        tick(); host_go = 1'b0;
        at_neg();
        chk("ready.go_ignored", {23'd0, ready}, 24'd1);

        // RUN: busy held for 100 sampled edges, layer traffic along the way
        tick(); busy = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            case (i)
                2:  begin cwr = 1'b1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'hABCDE; end
                3:  begin cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF; end
                4:  begin crd = 1'b0; cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h000; cdata_wr = 20'h11111; end
                5:  begin caddr_wr = 12'hFFF; cdata_wr = 20'h22222; end
                6:  begin caddr_wr = 12'h000; cdata_wr = 20'h33333; crd = 1'b1; caddr_rd = 12'h000; end
                7:  begin cwr = 1'b0; end
                8:  begin caddr_rd = 12'hFFF; host_rsel = 1'b0; host_raddr = 12'hFFF; end
                9:  begin crd = 1'b0; end
                10: begin crd = 1'b1; csel = 3'b011; caddr_rd = 12'h3FF | 12'h400; end
                11: begin crd = 1'b0; end
                100: begin busy = 1'b0; end
                default: ;
            endcase
            at_neg();
            case (i)
                1:  chk("ready.after_busy", {23'd0, ready}, 24'd0);
                3:  chk("cdata_rd.l1_3FF", {4'd0, cdata_rd}, 24'h0ABCDE);
                6:  chk("cdata_rd.war_old", {4'd0, cdata_rd}, 24'h011111);
                7:  chk("cdata_rd.war_new", {4'd0, cdata_rd}, 24'h033333);
                8:  begin
                        chk("cdata_rd.l0_FFF", {4'd0, cdata_rd}, 24'h022222);
                        chk("host_rdata.l0_FFF", {4'd0, host_rdata}, 24'h022222);
                    end
                9:  chk("cdata_rd.idle_zero", {4'd0, cdata_rd}, 24'd0);
                10: chk("cdata_rd.l1_highbits", {4'd0, cdata_rd}, 24'h0ABCDE);
                50: begin
                        chk("run.cycles_mid", run_cycles, 24'd49);
                        chk("run.err_clean", {23'd0, err}, 24'd0);
                    end
                default: ;
            endcase
        end
        tick();
        at_neg();
        chk("done.after_busy_fall", {23'd0, done}, 24'd1);
        chk("done.run_cycles", run_cycles, 24'd100);

        tick(); host_rsel = 1'b1; host_raddr = 12'h3FF;
        at_neg();
        chk("host_rdata.l1_3FF", {4'd0, host_rdata}, 24'h0ABCDE);
        tick(); host_go = 1'b1;
        tick(); host_go = 1'b0;
        at_neg();
        chk("done.go_ignored", {23'd0, done}, 24'd1);
        tick(); host_clr = 1'b1;
        tick(); host_clr = 1'b0; host_rsel = 1'b0; host_raddr = 12'h000;
        at_neg();
        chk("clr.done", {23'd0, done}, 24'd0);
        chk("clr.run_cycles", run_cycles, 24'd0);
        chk("clr.mem_retained", {4'd0, host_rdata}, 24'h033333);

        // bad bank select and out-of-range L1 write inside RUN
        tick(); host_go = 1'b1;
        tick(); host_go = 1'b0; busy = 1'b1;
        tick(); cwr = 1'b1; csel = 3'b010; caddr_wr = 12'h000; cdata_wr = 20'h77777;
        at_neg();
        chk("err.before_bad", {23'd0, err}, 24'd0);
        tick(); csel = 3'b011; caddr_wr = 12'h7FF; cdata_wr = 20'h5A5A5;
        at_neg();
        chk("err.bad_csel", {23'd0, err}, 24'd1);
        tick(); cwr = 1'b0; host_clr = 1'b1; host_rsel = 1'b1; host_raddr = 12'h3FF;
        at_neg();
        chk("l1.dropped_write", {4'd0, host_rdata}, 24'h0ABCDE);
        tick(); host_clr = 1'b0; host_rsel = 1'b0; host_raddr = 12'h000;
        at_neg();
        chk("l0.bad_csel_untouched", {4'd0, host_rdata}, 24'h033333);
        chk("run.clr_ignored", {23'd0, done}, 24'd0);
        chk("err.sticky_run", {23'd0, err}, 24'd1);
        tick(); busy = 1'b0;
        tick();
        at_neg();
        chk("err.sticky_done", {23'd0, err}, 24'd1);
        tick(); host_clr = 1'b1;
        tick(); host_clr = 1'b0;
        at_neg();
        chk("err.cleared", {23'd0, err}, 24'd0);

        // layer write strobe outside RUN
        tick(); cwr = 1'b1; csel = 3'b001; caddr_wr = 12'h000; cdata_wr = 20'h66666;
        tick(); cwr = 1'b0;
        at_neg();
        chk("err.cwr_idle", {23'd0, err}, 24'd1);
        chk("l0.idle_write_ignored", {4'd0, host_rdata}, 24'h033333);

        // reset in the middle of RUN
        tick(); host_go = 1'b1;
        tick(); host_go = 1'b0; busy = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        at_neg();
        chk("midrst.ready", {23'd0, ready}, 24'd0);
        chk("midrst.done", {23'd0, done}, 24'd0);
        chk("midrst.err", {23'd0, err}, 24'd0);
        chk("midrst.run_cycles", run_cycles, 24'd0);
        tick(); busy = 1'b0;
        at_neg();
        chk("midrst.run_cycles_held", run_cycles, 24'd0);
        tick(); reset = 1'b1;
        tick(); host_go = 1'b1;
        tick(); host_go = 1'b0;
        at_neg();
        chk("midrst.back_in_idle", {23'd0, ready}, 24'd1);

        // timeout on the short-timeout instance
        busy_to = 1'b1;
        repeat (50) tick();
        at_neg();
        chk("to.cycles_49", run_cycles_to, 24'd49);
        chk("to.not_done", {23'd0, done_to}, 24'd0);
        chk("to.err_clean", {23'd0, err_to}, 24'd0);
        tick();
        at_neg();
        chk("to.done", {23'd0, done_to}, 24'd1);
        chk("to.err", {23'd0, err_to}, 24'd1);
        chk("to.cycles_50", run_cycles_to, 24'd50);
        repeat (3) tick();
        at_neg();
        chk("to.cycles_frozen", run_cycles_to, 24'd50);
        busy_to = 1'b0;

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
